// File: rtl/ms_uart_pkg.sv
// ms_uart_pkg
//   Shared types and constants for the parametrised UART transmitter.
//   - parity_e   : frame parity mode as decoded from UCR[2:1]
//   - tx_state_e : serialiser FSM states
//   - UCR_*      : bit positions inside the UCR control register
package ms_uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int UCR_TXEN    = 0;
    localparam int UCR_PAR_LSB = 1;
    localparam int UCR_TWOSTOP = 3;
    localparam int UCR_OVFCLR  = 7;

    // Both 00 and 11 mean "no parity".
    function automatic parity_e decode_parity(input logic [1:0] field);
        case (field)
            2'b01:   return EVEN;
            2'b10:   return ODD;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/ms_uart_sync_fifo.sv
// ms_uart_sync_fifo
//   Single-clock FIFO with show-ahead head word.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     push, wr_data   : enqueue request and word; a push while full is only
//                       accepted when a pop happens in the same cycle
//     pop             : dequeue the head word (ignored while empty)
//     rd_data         : current head word, read straight from storage flops
//     full/empty/level: registered occupancy flags, valid after the edge
module ms_uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        do_push, do_pop;

    always_comb begin
        do_pop   = pop && !empty_q;
        // A pop in the same cycle frees the slot the push writes into.
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q + (AW + 1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(do_pop);
        level_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/ms_uart_tx_param.sv
// ms_uart_tx_param
//   UART transmitter: TX FIFO followed by a baud-timed serialiser.
//   Ports:
//     CLK, RESETN      : clock, asynchronous active-low reset
//     TX_DIN, write_fifo : word to enqueue and single-cycle enqueue strobe
//     UBRR             : baud divisor, one bit = UBRR+1 clocks
//     UCR              : [0] tx_en, [2:1] parity, [3] two_stop, [7] ovf_clr
//     TX               : serial line, idle high
//     tx_busy          : high while a frame is on the line
//     tx_full/tx_empty/tx_level : FIFO occupancy (registered)
//     tx_overflow      : sticky, set when a write was dropped
module ms_uart_tx_param
    import ms_uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [DATA_W-1:0] TX_DIN,
    input  logic              write_fifo,
    input  logic [15:0]       UBRR,
    input  logic [7:0]        UCR,
    output logic              TX,
    output logic              tx_busy,
    output logic              tx_full,
    output logic              tx_empty,
    output logic              tx_overflow,
    output logic [CNT_W-1:0]  tx_level
);

    localparam int IDX_W = $clog2(DATA_W);

    tx_state_e         state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              stop2_q, stop2_d;
    logic              ovf_q, ovf_d;

    // Frame registers: snapshot of word and configuration taken at pop.
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       ubrr_q, ubrr_d;
    parity_e           par_q, par_d;
    logic              two_stop_q, two_stop_d;

    logic              tx_en, tick, load, pop, drop, tx_bit;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty;
    logic              unused_ucr;

    assign tx_en      = UCR[UCR_TXEN];
    assign tick       = (cnt_q == ubrr_q);
    assign unused_ucr = ^UCR[6:4];

    ms_uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESETN),
        .push    (write_fifo),
        .wr_data (TX_DIN),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (tx_level)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = tick ? 16'd0 : cnt_q + 16'd1;
        bit_idx_d  = bit_idx_q;
        stop2_d    = stop2_q;
        data_d     = data_q;
        ubrr_d     = ubrr_q;
        par_d      = par_q;
        two_stop_d = two_stop_q;
        load       = 1'b0;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (tx_en && !fifo_empty) load = 1'b1;
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = (par_q == NONE) ? STOP : PARITY;
                        stop2_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (two_stop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else if (tx_en && !fifo_empty) begin
                        // Chain straight into the next frame, no idle gap.
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            pop        = 1'b1;
            state_d    = START;
            cnt_d      = 16'd0;
            data_d     = fifo_head;
            ubrr_d     = UBRR;
            par_d      = decode_parity(UCR[UCR_PAR_LSB +: 2]);
            two_stop_d = UCR[UCR_TWOSTOP];
        end

        // A drop in the same cycle as ovf_clr keeps the flag set.
        drop  = write_fifo && fifo_full && !pop;
        ovf_d = drop || (ovf_q && !UCR[UCR_OVFCLR]);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= '0;
            stop2_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            stop2_q   <= stop2_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        data_q     <= data_d;
        ubrr_q     <= ubrr_d;
        par_q      <= par_d;
        two_stop_q <= two_stop_d;
    end

    // Line level decoded from registered state, so reset forces it high at once.
    always_comb begin
        case (state_q)
            START:   tx_bit = 1'b0;
            DATA:    tx_bit = data_q[bit_idx_q];
            PARITY:  tx_bit = (par_q == ODD) ? ~(^data_q) : (^data_q);
            default: tx_bit = 1'b1;
        endcase
    end

    assign TX          = tx_bit;
    assign tx_busy     = (state_q != IDLE);
    assign tx_full     = fifo_full;
    assign tx_empty    = fifo_empty;
    assign tx_overflow = ovf_q;

endmodule

// File: tb/tb_ms_uart_tx_param.sv
module tb_ms_uart_tx_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          RESETN = 1'b0;
    logic [DW-1:0] TX_DIN = '0;
    logic          write_fifo = 1'b0;
    logic [15:0]   UBRR = 16'd0;
    logic [7:0]    UCR = 8'h00;
    logic          TX, tx_busy, tx_full, tx_empty, tx_overflow;
    logic [CW-1:0] tx_level;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected line level, one entry per clock of the frame(s) being sent.
    logic exp_q[$];
    logic [DW-1:0] w [17];
    logic [DW-1:0] w1, w2;
    logic [7:0]    cfg;
    logic [15:0]   ub;

    ms_uart_tx_param #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .TX_DIN      (TX_DIN),
        .write_fifo  (write_fifo),
        .UBRR        (UBRR),
        .UCR         (UCR),
        .TX          (TX),
        .tx_busy     (tx_busy),
        .tx_full     (tx_full),
        .tx_empty    (tx_empty),
        .tx_overflow (tx_overflow),
        .tx_level    (tx_level)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, LSB-first data, optional parity, stop bit(s),
    // each held for ubrr+1 clocks.
    task automatic add_frame(input logic [DW-1:0] d, input int ubrr, input logic [7:0] ucr);
        logic bits[$];
        logic p;
        p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            bits.push_back(d[i]);
            p = p ^ d[i];
        end
        if (ucr[2:1] == 2'b01) bits.push_back(p);
        if (ucr[2:1] == 2'b10) bits.push_back(!p);
        bits.push_back(1'b1);
        if (ucr[3]) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int r = 0; r <= ubrr; r++) exp_q.push_back(bits[k]);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        TX_DIN     = d;
        write_fifo = 1'b1;
        @(negedge CLK);
        write_fifo = 1'b0;
    endtask

    // Walk the expected waveform; optionally reprogram UBRR/UCR at one cycle.
    task automatic play(input string tag, input int chg_at, input logic [15:0] nu, input logic [7:0] nc);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge CLK);
            chk({tag, "_tx"}, TX, exp_q[i]);
            chk({tag, "_busy"}, tx_busy, 1);
            if (i == chg_at) begin
                UBRR = nu;
                UCR  = nc;
            end
        end
        exp_q.delete();
        @(negedge CLK);
        chk({tag, "_idle_tx"}, TX, 1);
        chk({tag, "_idle_busy"}, tx_busy, 0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_tx", TX, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_empty", tx_empty, 1);
        chk("rst_full", tx_full, 0);
        chk("rst_ovf", tx_overflow, 0);
        chk("rst_level", tx_level, 0);
        RESETN = 1'b1;
        @(negedge CLK);

        // 8N1, UBRR=3, 0x55
        UBRR = 16'd3;
        write_word(8'h55);
        chk("w1_level", tx_level, 1);
        add_frame(8'h55, 3, 8'h01);
        UCR = 8'h01;
        play("8n1", -1, 16'd0, 8'h00);
        chk("8n1_empty", tx_empty, 1);

        // Even and odd parity on 0x07
        UCR = 8'h00;
        write_word(8'h07);
        add_frame(8'h07, 3, 8'h03);
        UCR = 8'h03;
        play("even", -1, 16'd0, 8'h00);
        UCR = 8'h00;
        write_word(8'h07);
        add_frame(8'h07, 3, 8'h05);
        UCR = 8'h05;
        play("odd", -1, 16'd0, 8'h00);

        // Two stop bits, back to back
        UCR  = 8'h00;
        UBRR = 16'd1;
        write_word(8'hA1);
        write_word(8'h3C);
        chk("b2b_level", tx_level, 2);
        add_frame(8'hA1, 1, 8'h09);
        add_frame(8'h3C, 1, 8'h09);
        UCR = 8'h09;
        play("b2b", -1, 16'd0, 8'h00);

        // Randomised frames
        for (int t = 0; t < 6; t++) begin
            UCR = 8'h00;
            ub  = 16'($urandom_range(0, 3));
            cfg = {4'b0000, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
            w1  = DW'($urandom);
            UBRR = ub;
            write_word(w1);
            add_frame(w1, int'(ub), cfg);
            UCR = cfg;
            play("rand", -1, 16'd0, 8'h00);
        end

        // Overflow with tx_en=0
        UCR  = 8'h00;
        UBRR = 16'd0;
        for (int i = 0; i < 17; i++) begin
            w[i] = DW'($urandom);
            write_word(w[i]);
            if (i == 15) begin
                chk("ovf16_level", tx_level, 16);
                chk("ovf16_full", tx_full, 1);
                chk("ovf16_flag", tx_overflow, 0);
            end
        end
        chk("ovf_level", tx_level, 16);
        chk("ovf_full", tx_full, 1);
        chk("ovf_empty", tx_empty, 0);
        chk("ovf_flag", tx_overflow, 1);
        UCR = 8'h80;
        @(negedge CLK);
        chk("ovf_clr", tx_overflow, 0);
        write_word(DW'($urandom));
        chk("ovf_set_wins", tx_overflow, 1);
        @(negedge CLK);
        chk("ovf_clr2", tx_overflow, 0);
        UCR = 8'h00;
        chk("ovf_keep_level", tx_level, 16);
        for (int i = 0; i < 16; i++) add_frame(w[i], 0, 8'h01);
        UCR = 8'h01;
        play("drain", -1, 16'd0, 8'h00);
        chk("drain_empty", tx_empty, 1);
        chk("drain_level", tx_level, 0);

        // Mid-frame UBRR change and tx_en clear
        UCR  = 8'h00;
        UBRR = 16'd3;
        w1 = DW'($urandom);
        w2 = DW'($urandom) & 8'hF7;
        write_word(w1);
        write_word(w2);
        add_frame(w1, 3, 8'h01);
        UCR = 8'h01;
        play("mid", 20, 16'd9, 8'h00);
        chk("mid_level", tx_level, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            chk("mid_halt_tx", TX, 1);
        end
        chk("mid_halt_level", tx_level, 1);

        // Reset during DATA bit 3
        write_word(8'h00);
        chk("rmid_level", tx_level, 2);
        UBRR = 16'd3;
        add_frame(w2, 3, 8'h01);
        UCR = 8'h01;
        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            chk("rmid_tx", TX, exp_q[i]);
        end
        exp_q.delete();
        chk("rmid_pre_level", tx_level, 1);
        #2 RESETN = 1'b0;
        #1;
        chk("rmid_tx_async", TX, 1);
        chk("rmid_busy", tx_busy, 0);
        chk("rmid_empty", tx_empty, 1);
        chk("rmid_full", tx_full, 0);
        chk("rmid_ovf", tx_overflow, 0);
        chk("rmid_level", tx_level, 0);
        @(negedge CLK);
        RESETN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("post_rst_tx", TX, 1);
            chk("post_rst_busy", tx_busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ms_uart_tx_param.md
Name: ms_uart_tx_param

Overview:
- Parametrised next-generation UART transmitter: a configurable-depth TX FIFO feeding a baud-timed serialiser.
- Supports runtime parity mode and 1/2 stop bits, with a compile-time data width of 5..9 bits.
- Sits behind the AHB register slice. It is driven by the same TX_DIN / write_fifo / UBRR / UCR register set as the existing UART and reports status on UFR-style flags.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.
- CNT_W, $clog2(FIFO_DEPTH+1), width of the fill-level output.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RESETN  input  1  asynchronous active-low reset.
- TX_DIN  input  DATA_W  data word to enqueue.
- write_fifo  input  1  single-cycle enqueue strobe.
- UBRR  input  16  baud divisor; one bit period = UBRR+1 CLK cycles.
- UCR  input  8  control: [0] tx_en, [2:1] parity (00 none, 01 even, 10 odd, 11 none), [3] two_stop, [7] ovf_clr (level); [6:4] reserved.
- TX  output  1  serial line, idle high.
- tx_busy  output  1  a frame is in progress.
- tx_full  output  1  FIFO level == FIFO_DEPTH.
- tx_empty  output  1  FIFO level == 0.
- tx_overflow  output  1  sticky: a write was dropped.
- tx_level  output  CNT_W  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): TX=1, tx_busy=0, tx_empty=1, tx_full=0, tx_overflow=0, tx_level=0, FSM=IDLE, baud counter=0. Reset mid-frame aborts the frame and drives TX high immediately.
- FIFO write: accepted when write_fifo=1 and (!tx_full or a pop occurs in the same cycle). Otherwise the word is dropped and tx_overflow is set the next cycle.
- Overflow clear: tx_overflow clears while UCR[7]=1. If a drop and ovf_clr occur together, the set wins.
- Flag timing: tx_level, tx_full and tx_empty are registered and valid the cycle after the write/pop edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if tx_en and !tx_empty, pop the head word. In the same cycle, latch the word, UCR[3:1] and UBRR into frame registers, clear the baud counter, and go to START. TX goes low the next cycle, so latency is one cycle from a pop-eligible state.
- Baud counter: counts 0..UBRR_latched. A bit-end tick is asserted when count==UBRR_latched, after which the counter wraps to 0. UBRR=0 gives a one-cycle bit.
- START: TX=0 for one bit period, then DATA.
- DATA: TX=data[bit_idx], LSB first, bit_idx 0..DATA_W-1. On the last bit, go to PARITY if parity mode is 01/10, else go to STOP.
- PARITY: even mode gives TX = XOR of data bits; odd mode gives its inverse. Duration is one bit period.
- STOP: TX=1 for 1 bit period, or 2 if two_stop.
- End of STOP: if tx_en and !tx_empty, pop immediately and go to START with no idle gap. Otherwise go to IDLE.
- Mid-frame changes: the frame registers shield an in-flight frame from UCR/UBRR changes. Clearing tx_en mid-frame completes the current frame and then halts in IDLE; FIFO contents are retained.
- tx_busy=1 in every state except IDLE.

Decomposition:
- Package ms_uart_pkg holds:
  - parity_e (NONE, EVEN, ODD);
  - tx_state_e (IDLE, START, DATA, PARITY, STOP);
  - UCR bit-index constants (UCR_TXEN=0, UCR_PAR_LSB=1, UCR_TWOSTOP=3, UCR_OVFCLR=7).
- Sub-module ms_uart_sync_fifo #(WIDTH, DEPTH):
  - push/pop, full/empty/level outputs;
  - registered read data with show-ahead on the head word;
  - pointers one bit wider than the address for full/empty discrimination.
- The top level contains the baud counter, the FSM and the flag logic.

Test Plan:
- 8N1 waveform: DATA_W=8, UBRR=3, UCR=0x01, write 0x55 -> TX low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. Frame length 40 cycles; tx_busy high for exactly 40 cycles.
- Parity: UCR=0x03 (even), write 0x07 -> parity bit 1. UCR=0x05 (odd), write 0x07 -> parity bit 0. Frame length 11 bit periods in both cases.
- Two stop bits, back to back: UCR=0x09, UBRR=1, write 0xA1 then 0x3C -> STOP high for 4 cycles, the second START follows immediately, and no IDLE cycle is observed.
- Overflow: tx_en=0, FIFO_DEPTH=16, 17 writes -> tx_full=1, tx_level=16, tx_overflow=1, and the 17th word never appears on TX. Pulse UCR[7] -> tx_overflow=0.
- Mid-frame changes: during DATA, change UBRR from 3 to 9 and clear tx_en -> the current frame finishes at 4 cycles/bit, the FSM returns to IDLE, and tx_level is unchanged.
- Reset mid-frame: assert RESETN=0 during DATA bit 3 -> TX=1 asynchronously and all flags return to reset values. After release with tx_en=1 and an empty FIFO, TX stays high.
